// File: rtl/div_result_fifo.sv
// Result FIFO behind a restoring divider: captures {quo, rem, ov, divbyzero} on each
// rising edge of done and presents the oldest entry first-word-fall-through.
module div_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [4:0]               quo,
  input  logic [5:0]               rem,
  input  logic                     ov,
  input  logic                     divbyzero,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [4:0]               out_quo,
  output logic [5:0]               out_rem,
  output logic [1:0]               out_err,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL = CW'(DEPTH);

  // Entry layout: [12:8] quotient, [7:2] remainder, [1] divbyzero, [0] ov.
  logic [12:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_done_q;
  logic [3:0]    r_drop_cnt;

  logic          w_cap;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [AW:0]   w_count_nxt;
  logic [12:0]   w_head;

  // Handshake: an entry leaves on a rising edge where out_valid and out_ready are both
  // high; out_ready is ignored while out_valid is low, and out_valid never depends on it.
  assign w_cap  = done & ~r_done_q;
  assign w_pop  = ~r_empty & out_ready;
  assign w_wr   = w_cap & (~r_full | w_pop);
  assign w_drop = w_cap & r_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // Storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {quo, rem, divbyzero, ov};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_done_q   <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_done_q <= done;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
      if (w_drop && (r_drop_cnt != 4'd15)) begin
        r_drop_cnt <= r_drop_cnt + 4'd1;
      end
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = ~r_empty;
  assign out_quo   = r_empty ? 5'd0 : w_head[12:8];
  assign out_rem   = r_empty ? 6'd0 : w_head[7:2];
  assign out_err   = r_empty ? 2'd0 : w_head[1:0];
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_div_result_fifo.sv
// Directed bench for div_result_fifo: stimulus pushes expected entries into exp_q,
// a negedge monitor pops and compares whenever an entry is handed over.
module tb_div_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [4:0] quo;
  logic [5:0] rem;
  logic       ov;
  logic       divbyzero;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] out_quo;
  logic [5:0] out_rem;
  logic [1:0] out_err;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic [3:0] drop_cnt;

  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  div_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .done(done), .quo(quo), .rem(rem), .ov(ov),
    .divbyzero(divbyzero), .out_ready(out_ready), .out_valid(out_valid),
    .out_quo(out_quo), .out_rem(out_rem), .out_err(out_err), .full(full),
    .empty(empty), .count(count), .drop_cnt(drop_cnt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: an entry is consumed at the next rising edge when valid & ready here.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got entry %h expected none", {out_quo, out_rem, out_err});
      end else begin
        logic [12:0] exp_e;
        exp_e = exp_q.pop_front();
        check("pop_data", {out_quo, out_rem, out_err}, exp_e);
      end
    end
  end

  // Drivers
  task automatic set_data(input logic [4:0] q, input logic [5:0] r, input logic o, input logic z);
    quo = q; rem = r; ov = o; divbyzero = z;
  endtask

  task automatic send(input logic [4:0] q, input logic [5:0] r, input logic o, input logic z,
                      input bit keep);
    set_data(q, r, o, z);
    if (keep) exp_q.push_back({q, r, z, o});
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; done = 1'b0; out_ready = 1'b0;
    set_data(5'd0, 6'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 75/11 and 91/15 held back, no bypass into an empty FIFO
    set_data(5'd6, 6'd9, 1'b0, 1'b0);
    exp_q.push_back({5'd6, 6'd9, 2'b00});
    done = 1'b1;
    #2 check("no_bypass_valid", out_valid, 0);
    @(posedge clk); #1;
    check("after_write_valid", out_valid, 1);
    check("after_write_count", count, 1);
    done = 1'b0;
    @(posedge clk); #1;
    send(5'd6, 6'd1, 1'b0, 1'b0, 1'b1);
    check("two_held_count", count, 2);
    drain();

    // done held high 5 cycles: 213/25 captured once
    set_data(5'd8, 6'd13, 1'b0, 1'b0);
    exp_q.push_back({5'd8, 6'd13, 2'b00});
    done = 1'b1;
    repeat (5) @(posedge clk);
    #1 done = 1'b0;
    @(posedge clk); #1;
    check("held_done_count", count, 1);
    drain();

    // overflow then divide-by-zero error codes
    send(5'd31, 6'd0, 1'b1, 1'b0, 1'b1);
    send(5'd0, 6'd5, 1'b0, 1'b1, 1'b1);
    check("err_pair_count", count, 2);
    drain();

    // capture while empty with out_ready high: write only
    out_ready = 1'b1;
    set_data(5'd3, 6'd3, 1'b0, 1'b0);
    exp_q.push_back({5'd3, 6'd3, 2'b00});
    done = 1'b1;
    @(posedge clk); #1;
    check("empty_cap_pop_count", count, 1);
    done = 1'b0;
    drain();

    // simultaneous capture and pop with two entries stored
    send(5'd10, 6'd2, 1'b0, 1'b0, 1'b1);
    send(5'd11, 6'd3, 1'b0, 1'b0, 1'b1);
    set_data(5'd12, 6'd4, 1'b0, 1'b0);
    exp_q.push_back({5'd12, 6'd4, 2'b00});
    done = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; out_ready = 1'b0;
    check("mid_cap_pop_count", count, 2);
    @(posedge clk); #1;
    drain();

    // six captures into a 4-deep FIFO: two dropped
    for (int i = 1; i <= 6; i++) send(5'(i), 6'(i), 1'b0, 1'b0, i <= 4);
    check("overflow_full", full, 1);
    check("overflow_count", count, 4);
    check("overflow_drop", drop_cnt, 2);

    // full, pop and capture in the same cycle: accepted, lands last
    set_data(5'd9, 6'd9, 1'b0, 1'b0);
    exp_q.push_back({5'd9, 6'd9, 2'b00});
    done = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; out_ready = 1'b0;
    check("full_cap_pop_count", count, 4);
    check("full_cap_pop_drop", drop_cnt, 2);
    check("full_cap_pop_full", full, 1);
    @(posedge clk); #1;
    drain();

    // asynchronous reset between edges with 3 entries stored
    for (int i = 0; i < 3; i++) send(5'(20 + i), 6'(40 + i), 1'b0, 1'b0, 1'b1);
    check("pre_reset_count", count, 3);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("async_valid", out_valid, 0);
    check("async_full", full, 0);
    check("async_empty", empty, 1);
    check("async_count", count, 0);
    check("async_drop", drop_cnt, 0);
    check("async_quo", out_quo, 0);
    check("async_rem", out_rem, 0);
    check("async_err", out_err, 0);

    // done already high at the first edge after release is a capture
    set_data(5'd5, 6'd7, 1'b0, 1'b0);
    exp_q.push_back({5'd5, 6'd7, 2'b00});
    done = 1'b1;
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_capture", count, 1);
    done = 1'b0;
    @(posedge clk); #1;

    // fill, then 20 drops saturate drop_cnt
    for (int i = 0; i < 3; i++) send(5'(i + 1), 6'(i + 30), 1'b0, 1'b0, 1'b1);
    check("refill_full", full, 1);
    for (int i = 0; i < 20; i++) send(5'd17, 6'd17, 1'b0, 1'b0, 1'b0);
    check("drop_saturate", drop_cnt, 15);
    drain();
    check("drop_hold", drop_cnt, 15);

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
